// File: rtl/ps2_scancode_receiver.sv
// Receive-only PS/2 keyboard deserialiser: synchronises and glitch-filters the
// device-driven lines, frames 11-bit PS/2 words and emits 8-bit scan codes.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   ps2Clk         raw PS/2 clock line (asynchronous)
//   ps2Data        raw PS/2 data line (asynchronous)
//   scanCode       last correctly received byte, held until the next good frame
//   scanCodeReady  1-cycle strobe, scanCode updated
//   parityError    1-cycle strobe, frame dropped on odd-parity failure
//   frameError     1-cycle strobe, frame dropped on bad stop bit or timeout
module ps2_scancode_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       scanCodeReady,
  output logic       parityError,
  output logic       frameError
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic           dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_ok_q, parity_ok_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]     scan_code_q, scan_code_d;
  logic           ready_q, ready_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           fall_edge_c;

  // State register; sync flops and filtered clock idle high like the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_ok_q <= 1'b0;
      to_cnt_q    <= '0;
      scan_code_q <= '0;
      ready_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      to_cnt_q    <= to_cnt_d;
      scan_code_q <= scan_code_d;
      ready_q     <= ready_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  // Synchronisers, clock filter, frame FSM and timeout.
  always_comb begin
    state_d     = state_q;
    clk_s1_d    = ps2Clk;
    clk_s2_d    = clk_s1_q;
    dat_s1_d    = ps2Data;
    dat_s2_d    = dat_s1_q;
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    to_cnt_d    = to_cnt_q;
    scan_code_d = scan_code_q;
    ready_d     = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    fall_edge_c = 1'b0;

    // Flip the filtered level only after FILTER_LEN consecutive differing samples.
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d      = clk_s2_q;
        fall_edge_c = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        // A high bit while idle is line noise, not a start bit.
        if (fall_edge_c && !dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_edge_c) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_edge_c) begin
          parity_ok_d = ^{shift_q, dat_s2_q};
          state_d     = STOP;
        end
      end
      STOP: begin
        if (fall_edge_c) begin
          state_d = IDLE;
          // Stop-bit error outranks parity error.
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if (!parity_ok_q) begin
            perr_d = 1'b1;
          end else begin
            scan_code_d = shift_q;
            ready_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Mid-frame inactivity watchdog; a timeout never coincides with a fall edge.
    if (state_q != IDLE) begin
      if (fall_edge_c) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_d = '0;
        state_d  = IDLE;
        ferr_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TCW'(1);
      end
    end
  end

  assign scanCode      = scan_code_q;
  assign scanCodeReady = ready_q;
  assign parityError   = perr_q;
  assign frameError    = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Self-checking bench for ps2_scancode_receiver: drives PS/2 frames, queues the
// expected strobe/scan code per frame and checks them as the DUT reports.
module tb_ps2_scancode_receiver;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 40;

  localparam int K_READY = 1;
  localparam int K_PERR  = 2;
  localparam int K_FERR  = 3;

  typedef struct {
    int       kind;
    bit [7:0] code;
    bit       is_timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       ready, perr, ferr;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  longint     cyc = 0;
  longint     last_fall_cyc = 0;
  bit [7:0]   model_code = 8'h00;

  ps2_scancode_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2Clk(ps2_clk), .ps2Data(ps2_data),
    .scanCode(scan_code), .scanCodeReady(ready),
    .parityError(perr), .frameError(ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a clock-low half period.
  task automatic ps2_bit(input bit b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input bit [7:0] d, input bit bad_par, input bit stop);
    exp_t e;
    bit   p;
    p = (~^d) ^ bad_par;
    e.is_timeout = 1'b0;
    if (!stop) begin
      e.kind = K_FERR; e.code = model_code;
    end else if (bad_par) begin
      e.kind = K_PERR; e.code = model_code;
    end else begin
      e.kind = K_READY; e.code = d; model_code = d;
    end
    exp_q.push_back(e);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(stop);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst && (ready || perr || ferr)) begin
      int   kind;
      exp_t e;
      longint dly;
      check("one_strobe", longint'(ready) + longint'(perr) + longint'(ferr), 1);
      kind = ready ? K_READY : (perr ? K_PERR : K_FERR);
      dly  = cyc - last_fall_cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", kind, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", kind, e.kind);
        check("scan_code", scan_code, e.code);
        if (e.is_timeout)
          check("timeout_latency_ok", (dly >= FL + TO && dly <= FL + TO + 4) ? 1 : 0, 1);
        else
          check("stop_latency_ok", (dly >= FL + 1 && dly <= FL + 4) ? 1 : 0, 1);
      end
    end
  end

  initial begin
    exp_t e;
    int   guard;
    wait_cyc(4);
    rst = 1'b0;
    // Idle lines: no strobes, reset scan code.
    wait_cyc(100);
    check("reset_scan_code", scan_code, 8'h00);
    check("reset_no_ready", ready, 0);

    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("code_after_parity_err", scan_code, 8'h1C);
    send_frame(8'h29, 1'b0, 1'b0);
    check("code_after_frame_err", scan_code, 8'h1C);

    // Short low glitch while idle must be filtered out.
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(50);

    // Start plus four data bits, then silence: expect a timeout frame error.
    e.kind = K_FERR; e.code = model_code; e.is_timeout = 1'b1;
    exp_q.push_back(e);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_cyc(TO + 100);
    check("timeout_drained", exp_q.size(), 0);
    send_frame(8'h75, 1'b0, 1'b1);

    // Reset after six bits discards the partial frame and clears the code.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    model_code = 8'h00;
    wait_cyc(20);
    check("code_after_midframe_rst", scan_code, 8'h00);
    send_frame(8'h66, 1'b0, 1'b1);
    check("final_code", scan_code, 8'h66);

    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      wait_cyc(1);
      guard++;
    end
    check("queue_empty_at_end", exp_q.size(), 0);
    wait_cyc(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
